// File: rtl/uart_tx_arb.sv
`default_nettype none
// uart_tx_arb: four-way round-robin arbiter feeding one UART formatter, with a
// start-strobe handshake and a watchdog on the formatter's busy response.
module uart_tx_arb #(
  parameter int DW     = 16,
  parameter int WD_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req_valid_i,
  input  logic [4*DW-1:0] req_data_i,
  output logic [3:0]      req_ready_o,
  output logic [DW-1:0]   tx_data_o,
  output logic [1:0]      tx_rg_o,
  output logic            tx_stb_o,
  input  logic            tx_busy_i,
  output logic            arb_busy_o,
  output logic [1:0]      last_grant_o,
  output logic            wd_err_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] WD_LIMIT = 4'(WD_MAX);

  state_t        state_q;
  logic [1:0]    last_grant_q;
  logic [1:0]    tx_rg_q;
  logic [DW-1:0] tx_data_q;
  logic [3:0]    wd_q;
  logic [3:0]    wd_d;
  logic          wd_err_q;

  logic          w_found;
  logic [1:0]    w_pick;
  logic [1:0]    w_cand;

  // Search starts one past the previous winner so a held request cannot starve.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_cand  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = last_grant_q + 2'(k);
      if (!w_found && req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign wd_d = wd_q + 4'd1;

  // Handshake strobes are masked during reset so an aborted cycle transfers nothing.
  assign req_ready_o  = (state_q == IDLE && w_found && !rst) ? (4'b0001 << w_pick) : 4'b0000;
  assign tx_stb_o     = (state_q == ISSUE) && !tx_busy_i && !rst;
  assign arb_busy_o   = (state_q != IDLE);
  assign tx_data_o    = tx_data_q;
  assign tx_rg_o      = tx_rg_q;
  assign last_grant_o = last_grant_q;
  assign wd_err_o     = wd_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      tx_rg_q      <= 2'd0;
      tx_data_q    <= '0;
      wd_q         <= 4'd0;
      wd_err_q     <= 1'b0;
    end else begin
      wd_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_found) begin
            tx_data_q    <= req_data_i[w_pick*DW +: DW];
            tx_rg_q      <= w_pick;
            last_grant_q <= w_pick;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q <= 4'd0;
          if (!tx_busy_i) begin
            state_q <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (tx_busy_i) begin
            wd_q    <= 4'd0;
            state_q <= WAIT_DONE;
          end else if (wd_d == WD_LIMIT) begin
            wd_q     <= 4'd0;
            wd_err_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            wd_q <= wd_d;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// tb_uart_tx_arb: randomized requesters and formatter against a transaction-level
// arbiter model; expected grants, strobes and watchdog pulses flow through queues.
module tb_uart_tx_arb;
  localparam int DW     = 16;
  localparam int WD_MAX = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req_valid = 4'b0;
  logic [4*DW-1:0] req_data = '0;
  logic [3:0]      req_ready;
  logic [DW-1:0]   tx_data;
  logic [1:0]      tx_rg;
  logic            tx_stb;
  logic            tx_busy = 1'b0;
  logic            arb_busy;
  logic [1:0]      last_grant;
  logic            wd_err;

  always #5 clk = ~clk;

  uart_tx_arb #(.DW(DW), .WD_MAX(WD_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .tx_data_o(tx_data), .tx_rg_o(tx_rg), .tx_stb_o(tx_stb), .tx_busy_i(tx_busy),
    .arb_busy_o(arb_busy), .last_grant_o(last_grant), .wd_err_o(wd_err)
  );

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] data;
  } ev_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 0;
  ev_t q_grant[$];
  ev_t q_stb[$];
  int  q_wd[$];
  int  glog[$];
  int  wd_seen = 0;

  // Reference model: who owns the formatter, and how far its job has got.
  int            m_owner = -1;
  bit            m_strobed = 0;
  bit            m_started = 0;
  int            m_wd = 0;
  int            m_last = 3;
  int            m_rg = 0;
  logic [DW-1:0] m_data = '0;
  int            m_pick;
  int            p_rg = 0;
  int            p_last = 3;
  logic [DW-1:0] p_data = '0;
  bit            p_busy = 0;

  // Stimulus-side state.
  bit   [3:0] pend = 4'b0;
  int         gen_prob = 0;
  int         fmt_mode = 0;
  int         fixed_len = 6;
  bit         ext_busy = 0;
  int         cnt = 0;
  logic [3:0] acc = 4'b0;
  logic       stb_seen = 1'b0;
  logic       prev_stb = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic missing(input string name, input int at);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d actual=absent required=event_at_%0d", name, cyc, at);
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    p_rg   = m_rg;
    p_last = m_last;
    p_data = m_data;
    p_busy = (m_owner >= 0);
    if (rst) begin
      m_owner = -1; m_strobed = 0; m_started = 0; m_wd = 0;
      m_last = 3; m_rg = 0; m_data = '0;
    end else if (m_owner < 0) begin
      if (req_valid != 4'b0) begin
        m_pick = 0;
        for (int k = 4; k >= 1; k--)
          if (req_valid[(m_last + k) % 4]) m_pick = (m_last + k) % 4;
        m_owner   = m_pick;
        m_last    = m_pick;
        m_rg      = m_pick;
        m_data    = req_data[m_pick*DW +: DW];
        m_strobed = 0;
        q_grant.push_back('{cyc, m_pick, m_data});
      end
    end else if (!m_strobed) begin
      if (!tx_busy) begin
        q_stb.push_back('{cyc, m_rg, m_data});
        m_strobed = 1; m_started = 0; m_wd = 0;
      end
    end else if (!m_started) begin
      if (tx_busy) m_started = 1;
      else begin
        m_wd++;
        if (m_wd == WD_MAX) begin
          q_wd.push_back(cyc + 1);
          m_owner = -1;
        end
      end
    end else if (!tx_busy) begin
      m_owner = -1;
    end
    mon_en = 1;
  end

  initial forever begin
    ev_t e;
    @(negedge clk);
    acc      = req_valid & req_ready;
    stb_seen = tx_stb;
    if (mon_en) begin
      check("tx_data", tx_data, p_data);
      check("tx_rg", tx_rg, p_rg);
      check("last_grant", last_grant, p_last);
      check("arb_busy", arb_busy, p_busy);
      while (q_grant.size() > 0 && q_grant[0].cyc < cyc) begin
        missing("grant", q_grant[0].cyc); void'(q_grant.pop_front());
      end
      while (q_stb.size() > 0 && q_stb[0].cyc < cyc) begin
        missing("tx_stb", q_stb[0].cyc); void'(q_stb.pop_front());
      end
      while (q_wd.size() > 0 && q_wd[0] < cyc) begin
        missing("wd_err", q_wd[0]); void'(q_wd.pop_front());
      end
      if (req_ready != 4'b0) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) glog.push_back(i);
        if (q_grant.size() == 0) check("grant_unexpected", req_ready, 0);
        else begin
          e = q_grant.pop_front();
          check("grant_cycle", cyc, e.cyc);
          check("req_ready", req_ready, 4'b0001 << e.idx);
        end
      end
      if (tx_stb) begin
        check("stb_back_to_back", prev_stb, 0);
        if (q_stb.size() == 0) check("stb_unexpected", tx_stb, 0);
        else begin
          e = q_stb.pop_front();
          check("stb_cycle", cyc, e.cyc);
          check("stb_rg", tx_rg, e.idx);
          check("stb_data", tx_data, e.data);
        end
      end
      if (wd_err) begin
        wd_seen++;
        if (q_wd.size() == 0) check("wd_unexpected", wd_err, 0);
        else check("wd_cycle", cyc, q_wd.pop_front());
      end
    end
    prev_stb = tx_stb;
  end

  // Advance one cycle: retire accepted requests, raise new ones, run the formatter.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        pend[i] = 1'b0;
        if ($urandom_range(0, 1) == 1) req_data[i*DW +: DW] = DW'($urandom);
      end
      if (!pend[i] && $urandom_range(0, 99) < gen_prob) begin
        pend[i] = 1'b1;
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    req_valid = pend;
    if (cnt > 0) cnt--;
    if (stb_seen && fmt_mode == 0) cnt = (fixed_len > 0) ? fixed_len : $urandom_range(1, 6);
    tx_busy = (cnt > 0) || ext_busy;
  endtask

  task automatic post(input int i, input logic [DW-1:0] d);
    pend[i]              = 1'b1;
    req_valid[i]         = 1'b1;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int wd_before;
    repeat (3) step();
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_tx_stb", tx_stb, 0);
    check("rst_wd_err", wd_err, 0);
    check("rst_arb_busy", arb_busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_rg", tx_rg, 0);
    check("rst_last_grant", last_grant, 3);
    rst = 1'b0;

    glog.delete();
    post(0, 16'h1111);
    post(2, 16'h2222);
    repeat (30) step();
    check("order_a_len", glog.size(), 2);
    if (glog.size() == 2) begin
      check("order_a_0", glog[0], 0);
      check("order_a_1", glog[1], 2);
    end

    pulse_rst();
    glog.delete();
    fixed_len = 6;
    gen_prob  = 100;
    repeat (50) step();
    gen_prob = 0;
    check("order_b_len_ge5", glog.size() >= 5, 1);
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("order_b", glog[i], i % 4);
    end
    repeat (50) step();

    ext_busy = 1'b1;
    step();
    post(1, 16'h5A5A);
    repeat (4) step();
    check("stb_held_while_busy", tx_stb, 0);
    ext_busy = 1'b0;
    repeat (20) step();

    wd_before = wd_seen;
    fmt_mode  = 1;
    post(2, 16'hC0DE);
    step();
    post(3, 16'hD00D);
    repeat (18) step();
    fmt_mode = 0;
    repeat (40) step();
    check("wd_pulse_count", wd_seen - wd_before, 2);

    post(0, 16'hBEEF);
    for (int i = 0; i < 5 && pend[0]; i++) step();
    check("beef_accepted", pend[0], 0);
    req_data[DW-1:0] = 16'h1234;
    repeat (6) step();
    check("beef_hold", tx_data, 16'hBEEF);
    repeat (20) step();

    post(1, 16'h7777);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_tx_rg", tx_rg, 0);
    check("mid_rst_last", last_grant, 3);
    check("mid_rst_busy", arb_busy, 0);
    check("mid_rst_stb", tx_stb, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) post(i, DW'($urandom));
    #1;
    check("post_rst_winner", req_ready, 4'b0001);
    repeat (60) step();

    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        gen_prob  = $urandom_range(10, 80);
        fmt_mode  = ($urandom_range(0, 9) == 0) ? 1 : 0;
        fixed_len = 0;
      end
      if ($urandom_range(0, 99) < 3) ext_busy = ~ext_busy;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    rst = 1'b0; gen_prob = 0; fmt_mode = 0; ext_busy = 1'b0;
    repeat (80) step();
    check("drain_grant_q", q_grant.size(), 0);
    check("drain_stb_q", q_stb.size(), 0);
    check("drain_wd_q", q_wd.size(), 0);
    check("drain_pending", pend, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
